// File: rtl/remind_alert.sv
// Hydration alert driver: turns the registered remind level into a beeping, snoozable, acknowledgeable alert.
// Optional build macro REMIND_ESCALATE_EN: once all snoozes are spent, the buzzer sounds continuously in ALERT.
module remind_alert #(
  parameter int TICK_DIV       = 50000000,
  parameter int BEEP_ON_TICKS  = 1,
  parameter int BEEP_OFF_TICKS = 1,
  parameter int SNOOZE_TICKS   = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       remind,
  input  logic       ack_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic       led,
  output logic [1:0] state,
  output logic [1:0] snooze_used
);

  typedef enum logic [1:0] {IDLE = 2'b00, ALERT = 2'b01, SNOOZE = 2'b10, ACKED = 2'b11} state_t;

  localparam int TW       = $clog2(TICK_DIV);
  localparam int BEEP_MAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
  localparam int BW       = $clog2(BEEP_MAX + 1);
  localparam int SW       = $clog2(SNOOZE_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] ON_LAST     = BW'(BEEP_ON_TICKS - 1);
  localparam logic [BW-1:0] OFF_LAST    = BW'(BEEP_OFF_TICKS - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_TICKS);
  localparam logic [1:0]    SNOOZE_CAP  = 2'(MAX_SNOOZE);

  state_t          cur_state, state_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [BW-1:0]   beep_cnt, beep_n;
  logic [SW-1:0]   timer, timer_n;
  logic [1:0]      used_n;
  logic            beep_phase, phase_n;
  logic            tick;
  logic            ack_p0, ack_p1, ack_p2;
  logic            snz_p0, snz_p1, snz_p2;
  logic            ack_evt, snz_evt;

  // p0/p1 resynchronise the raw buttons; p2 holds the previous synchronized value for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_p0 <= 1'b0;
      ack_p1 <= 1'b0;
      ack_p2 <= 1'b0;
      snz_p0 <= 1'b0;
      snz_p1 <= 1'b0;
      snz_p2 <= 1'b0;
    end else begin
      ack_p0 <= ack_btn;
      ack_p1 <= ack_p0;
      ack_p2 <= ack_p1;
      snz_p0 <= snooze_btn;
      snz_p1 <= snz_p0;
      snz_p2 <= snz_p1;
    end
  end

  assign ack_evt = ack_p1 & ~ack_p2;
  assign snz_evt = snz_p1 & ~snz_p2;
  assign tick    = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= IDLE;
      tick_cnt    <= '0;
      beep_cnt    <= '0;
      beep_phase  <= 1'b0;
      timer       <= '0;
      snooze_used <= '0;
    end else begin
      cur_state   <= state_n;
      tick_cnt    <= tick_n;
      beep_cnt    <= beep_n;
      beep_phase  <= phase_n;
      timer       <= timer_n;
      snooze_used <= used_n;
    end
  end

  always_comb begin
    state_n = cur_state;
    tick_n  = tick ? '0 : tick_cnt + TW'(1);
    beep_n  = beep_cnt;
    phase_n = beep_phase;
    timer_n = timer;
    used_n  = snooze_used;
    case (cur_state)
      IDLE: begin
        used_n = '0;
        if (remind) begin
          state_n = ALERT;
          tick_n  = '0;
          beep_n  = '0;
          phase_n = 1'b1;
        end
      end
      ALERT: begin
        if (ack_evt) begin
          state_n = ACKED;
        end else if (!remind) begin
          state_n = IDLE;
        end else if (snz_evt && (snooze_used < SNOOZE_CAP)) begin
          state_n = SNOOZE;
          used_n  = snooze_used + 2'd1;
          timer_n = SNOOZE_LOAD;
          tick_n  = '0;
        end else if (tick) begin
          // A rejected snooze falls through here so the beep keeps its cadence
          if (beep_phase ? (beep_cnt == ON_LAST) : (beep_cnt == OFF_LAST)) begin
            phase_n = ~beep_phase;
            beep_n  = '0;
          end else begin
            beep_n = beep_cnt + BW'(1);
          end
        end
      end
      SNOOZE: begin
        if (ack_evt) begin
          state_n = ACKED;
        end else if (!remind) begin
          state_n = IDLE;
        end else if (tick) begin
          if (timer == SW'(1)) begin
            state_n = ALERT;
            tick_n  = '0;
            beep_n  = '0;
            phase_n = 1'b1;
          end else begin
            timer_n = timer - SW'(1);
          end
        end
      end
      ACKED: begin
        if (!remind) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    buzzer = 1'b0;
    led    = 1'b0;
    case (cur_state)
      ALERT: begin
        led    = 1'b1;
        buzzer = beep_phase;
`ifdef REMIND_ESCALATE_EN
        if (snooze_used == SNOOZE_CAP) buzzer = 1'b1;
`endif
      end
      SNOOZE:  led = tick_cnt[TW-1];
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule
